axis2vid: RTL and testbench



---
 rtl/axis2vid_pkg.sv | 32 +++
 rtl/axis2vid_if.sv | 26 ++
 rtl/axis2vid_timing_gen.sv | 58 +++++
 rtl/axis2vid.sv | 179 +++++++++++++++++
 tb/tb_axis2vid.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis2vid_pkg.sv
// axis2vid_pkg: shared definitions for the AXI-stream to parallel video path.
//   - Handshake FSM state encoding (HUNT, WAIT, RUN).
//   - Timing helpers deriving line/frame totals and sync window bounds
//     from the porch/sync parameters.
//   - RGB565 colour-bar helper used by the optional unlocked test pattern
//     (AXIS2VID_PATTERN_EN).
package axis2vid_pkg;

  localparam int DATA_W = 16;

  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  function automatic int line_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int sync_first(input int act, input int fp);
    return act + fp;
  endfunction

  function automatic int sync_last(input int act, input int fp, input int sync);
    return act + fp + sync - 1;
  endfunction

  // Bar index bit 2 -> red, bit 1 -> green, bit 0 -> blue, each at full scale.
  function automatic logic [DATA_W-1:0] bar_rgb565(input logic [2:0] idx);
    return {idx[2] ? 5'h1F : 5'h00, idx[1] ? 6'h3F : 6'h00, idx[0] ? 5'h1F : 5'h00};
  endfunction

endpackage

// File: rtl/axis2vid_if.sv
// axis2vid_if: AXI-stream pixel bus feeding axis2vid.
//   axis_tdata  [15:0] pixel        axis_tvalid  beat valid
//   axis_tready        beat taken   axis_tuser   start of frame
//   axis_tlast         end of line  axis_tkeep   [1:0], carried but unused
// Modports: master = pixel producer, slave = axis2vid.
interface axis2vid_if;
  import axis2vid_pkg::*;

  logic [DATA_W-1:0] axis_tdata;
  logic              axis_tvalid;
  logic              axis_tready;
  logic              axis_tuser;
  logic              axis_tlast;
  logic [1:0]        axis_tkeep;

  modport master (
    output axis_tdata, axis_tvalid, axis_tuser, axis_tlast, axis_tkeep,
    input  axis_tready
  );

  modport slave (
    input  axis_tdata, axis_tvalid, axis_tuser, axis_tlast, axis_tkeep,
    output axis_tready
  );

endinterface

// File: rtl/axis2vid_timing_gen.sv
// vid_timing_gen: free-running raster counters and region decode.
// Ports:
//   vid_clk, reset (async, active-high)
//   h_cnt, v_cnt : current raster position
//   act          : position inside the active picture
//   hs, vs       : position inside the horizontal / vertical sync window
//   sof_pos      : position (0,0), first active pixel of a frame
// All decode outputs are combinational from the counters.
module vid_timing_gen
  import axis2vid_pkg::*;
#(
  parameter int H_ACT   = 1280,
  parameter int H_FP    = 110,
  parameter int H_SYNC  = 40,
  parameter int H_BP    = 220,
  parameter int V_ACT   = 720,
  parameter int V_FP    = 5,
  parameter int V_SYNC  = 5,
  parameter int V_BP    = 20,
  parameter int CNT_WID = 12
) (
  input  logic               vid_clk,
  input  logic               reset,
  output logic [CNT_WID-1:0] h_cnt,
  output logic [CNT_WID-1:0] v_cnt,
  output logic               act,
  output logic               hs,
  output logic               vs,
  output logic               sof_pos
);

  localparam logic [CNT_WID-1:0] H_LAST   = CNT_WID'(line_total(H_ACT, H_FP, H_SYNC, H_BP) - 1);
  localparam logic [CNT_WID-1:0] V_LAST   = CNT_WID'(line_total(V_ACT, V_FP, V_SYNC, V_BP) - 1);
  localparam logic [CNT_WID-1:0] H_ACT_C  = CNT_WID'(H_ACT);
  localparam logic [CNT_WID-1:0] V_ACT_C  = CNT_WID'(V_ACT);
  localparam logic [CNT_WID-1:0] HS_FIRST = CNT_WID'(sync_first(H_ACT, H_FP));
  localparam logic [CNT_WID-1:0] HS_LAST  = CNT_WID'(sync_last(H_ACT, H_FP, H_SYNC));
  localparam logic [CNT_WID-1:0] VS_FIRST = CNT_WID'(sync_first(V_ACT, V_FP));
  localparam logic [CNT_WID-1:0] VS_LAST  = CNT_WID'(sync_last(V_ACT, V_FP, V_SYNC));

  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign act     = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign hs      = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs      = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  assign sof_pos = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/axis2vid.sv
// axis2vid: AXI-stream pixel stream (tuser = SOF, tlast = EOL) to parallel
// video (hsync, vsync, de, data) on a single pixel clock.
// Ports:
//   vid_clk, reset           : pixel clock, async active-high reset
//   axis (axis2vid_if.slave) : incoming pixel stream
//   vid_hsync, vid_vsync     : syncs, active level set by SYNC_POL
//   vid_de, vid_data         : data enable and pixel, data 0 when not enabled
//   locked                   : stream aligned to raster (FSM in RUN)
//   err_sof, err_eol         : one-cycle pulses on SOF / EOL misalignment
//   err_uflow                : one-cycle pulse when an active pixel had no data
// Optional: define AXIS2VID_PATTERN_EN to show 8 vertical colour bars while
// unlocked; otherwise the output is blanked while unlocked.
module axis2vid
  import axis2vid_pkg::*;
#(
  parameter int H_ACT    = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACT    = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit SYNC_POL = 1'b1,
  parameter int CNT_WID  = 12
) (
  input  logic              vid_clk,
  input  logic              reset,
  axis2vid_if.slave         axis,
  output logic              vid_hsync,
  output logic              vid_vsync,
  output logic              vid_de,
  output logic [DATA_W-1:0] vid_data,
  output logic              locked,
  output logic              err_sof,
  output logic              err_eol,
  output logic              err_uflow
);

  localparam logic [CNT_WID-1:0] H_EOL = CNT_WID'(H_ACT - 1);

  logic [CNT_WID-1:0] h_cnt_p0;
  logic [CNT_WID-1:0] v_cnt_p0;
  logic               act_p0;
  logic               hs_p0;
  logic               vs_p0;
  logic               sof_pos_p0;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               tready_p0;
  logic               run_p0;
  logic               accept_p0;
  logic               sof_bad_p0;
  logic               eol_bad_p0;
  logic               idle_de_p0;
  logic [DATA_W-1:0]  idle_data_p0;

  logic               hsync_p1;
  logic               vsync_p1;
  logic               vld_p1;
  logic [DATA_W-1:0]  data_p1;
  logic               err_sof_p1;
  logic               err_eol_p1;
  logic               err_uflow_p1;

  logic               unused_bits;

  vid_timing_gen #(
    .H_ACT   (H_ACT),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACT   (V_ACT),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .CNT_WID (CNT_WID)
  ) u_timing (
    .vid_clk (vid_clk),
    .reset   (reset),
    .h_cnt   (h_cnt_p0),
    .v_cnt   (v_cnt_p0),
    .act     (act_p0),
    .hs      (hs_p0),
    .vs      (vs_p0),
    .sof_pos (sof_pos_p0)
  );

  assign unused_bits = ^{axis.axis_tkeep, v_cnt_p0};

  // p0: raster position from the timing generator, handshake decided here.
  // WAIT already behaves as RUN in the (0,0) cycle so the SOF beat is fetched
  // for the first pixel instead of one frame later.
  assign run_p0 = (state == RUN) || ((state == WAIT) && sof_pos_p0);

  always_comb begin
    tready_p0 = 1'b0;
    if (!reset) begin
      case (state)
        HUNT:    tready_p0 = !(axis.axis_tvalid && axis.axis_tuser);
        WAIT:    tready_p0 = sof_pos_p0 && act_p0;
        RUN:     tready_p0 = act_p0;
        default: tready_p0 = 1'b0;
      endcase
    end
  end

  assign axis.axis_tready = tready_p0;
  assign accept_p0        = axis.axis_tvalid && tready_p0;

  // SOF at the frame origin is mandatory; a SOF anywhere before the last
  // pixel of a line means the producer has restarted a frame mid-stream.
  assign sof_bad_p0 = run_p0 && accept_p0 &&
                      (sof_pos_p0 ? !axis.axis_tuser
                                  : (axis.axis_tuser && (h_cnt_p0 < H_EOL)));
  assign eol_bad_p0 = run_p0 && accept_p0 && (axis.axis_tlast != (h_cnt_p0 == H_EOL));

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (axis.axis_tvalid && axis.axis_tuser) state_nxt = WAIT;
      WAIT:    if (sof_pos_p0) state_nxt = sof_bad_p0 ? HUNT : RUN;
      RUN:     if (sof_bad_p0) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

`ifdef AXIS2VID_PATTERN_EN
  logic [CNT_WID+2:0] bar_q_p0;
  logic               unused_bar_hi;

  assign bar_q_p0      = {h_cnt_p0, 3'b000} / (CNT_WID+3)'(H_ACT);
  assign unused_bar_hi = ^bar_q_p0[CNT_WID+2:3];
  assign idle_de_p0    = act_p0;
  assign idle_data_p0  = act_p0 ? bar_rgb565(bar_q_p0[2:0]) : '0;
`else
  assign idle_de_p0    = 1'b0;
  assign idle_data_p0  = '0;
`endif

  // p1: registered video outputs, one clock behind the raster position.
  always_ff @(posedge vid_clk or posedge reset) begin
    if (reset) begin
      state        <= HUNT;
      hsync_p1     <= ~SYNC_POL;
      vsync_p1     <= ~SYNC_POL;
      vld_p1       <= 1'b0;
      data_p1      <= '0;
      err_sof_p1   <= 1'b0;
      err_eol_p1   <= 1'b0;
      err_uflow_p1 <= 1'b0;
    end else begin
      state        <= state_nxt;
      hsync_p1     <= hs_p0 ? SYNC_POL : ~SYNC_POL;
      vsync_p1     <= vs_p0 ? SYNC_POL : ~SYNC_POL;
      err_sof_p1   <= sof_bad_p0;
      err_eol_p1   <= eol_bad_p0;
      err_uflow_p1 <= run_p0 && act_p0 && !axis.axis_tvalid;
      if (run_p0) begin
        vld_p1  <= act_p0;
        data_p1 <= (act_p0 && axis.axis_tvalid) ? axis.axis_tdata : '0;
      end else begin
        vld_p1  <= idle_de_p0;
        data_p1 <= idle_data_p0;
      end
    end
  end

  assign vid_hsync = hsync_p1;
  assign vid_vsync = vsync_p1;
  assign vid_de    = vld_p1;
  assign vid_data  = data_p1;
  assign locked    = (state == RUN);
  assign err_sof   = err_sof_p1;
  assign err_eol   = err_eol_p1;
  assign err_uflow = err_uflow_p1;

endmodule

// File: tb/tb_axis2vid.sv
// tb_axis2vid: testbench for axis2vid with a tiny raster
// (4+1+1+1 clocks per line, 3+1+1+1 lines per frame).
// A table of per-slot records (beat to send, expected display) feeds a beat
// source queue and an expected-output scoreboard; hand-written sequences cover
// reset values, asynchronous reset mid-line and SOF hold in HUNT/WAIT.
module tb_axis2vid;
  import axis2vid_pkg::*;

  localparam int HA = 4;
  localparam int HT = 7;
  localparam int VA = 3;
  localparam int VT = 6;
  localparam int HS_AT = 5;
  localparam int VS_AT = 4;

  logic        vid_clk = 1'b0;
  logic        reset;
  logic        vid_hsync, vid_vsync, vid_de, locked;
  logic        err_sof, err_eol, err_uflow;
  logic [15:0] vid_data;

  always #5 vid_clk = ~vid_clk;

  axis2vid_if bus ();

  axis2vid #(
    .H_ACT(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .CNT_WID(12)
  ) dut (
    .vid_clk   (vid_clk),
    .reset     (reset),
    .axis      (bus),
    .vid_hsync (vid_hsync),
    .vid_vsync (vid_vsync),
    .vid_de    (vid_de),
    .vid_data  (vid_data),
    .locked    (locked),
    .err_sof   (err_sof),
    .err_eol   (err_eol),
    .err_uflow (err_uflow)
  );

  typedef struct {
    logic        has_beat;
    logic [15:0] data;
    logic        user;
    logic        last;
    int          hold;
    logic        shown;
    logic [15:0] exp_data;
    logic        exp_uflow;
    logic        exp_sof;
    logic        exp_eol;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        user;
    logic        last;
    int          hold;
  } beat_t;

  typedef struct {
    logic [15:0] data;
    logic        uflow;
    logic        sof;
    logic        eol;
  } exp_t;

  vec_t  vecs[$];
  beat_t src_q[$];
  exp_t  sb_q[$];

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   tb_pos = 0;
  int   lock_falls = 0;
  logic prev_locked = 1'b0;
  logic acc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (pos %0d)", name, got, want, tb_pos);
  endtask

  task automatic add_vec(input logic hb, input logic [15:0] d, input logic u, input logic l,
                         input int hold, input logic sh, input logic [15:0] ed,
                         input logic eu, input logic es, input logic ee);
    vec_t v;
    v.has_beat = hb; v.data = d; v.user = u; v.last = l; v.hold = hold;
    v.shown = sh; v.exp_data = ed; v.exp_uflow = eu; v.exp_sof = es; v.exp_eol = ee;
    vecs.push_back(v);
  endtask

  // kind 0 normal, 1 one-cycle gap before pixel 6, 2 bad tlast on 3 and 8,
  // 3 no tuser on first beat, 4 extra tuser on last pixel of line 0,
  // 5 extra tuser on pixel 2.
  task automatic add_frame(input int kind);
    for (int i = 1; i <= 12; i++) begin
      logic [15:0] d;
      d = 16'(i);
      case (kind)
        1: begin
          if (i == 6) add_vec(1'b0, 16'h0, 1'b0, 1'b0, 0, 1'b1, 16'h0, 1'b1, 1'b0, 1'b0);
          if (i <= 5) add_vec(1'b1, d, i == 1, i == 4, 0, 1'b1, d, 1'b0, 1'b0, 1'b0);
          else if (i <= 11)
            add_vec(1'b1, d, 1'b0, (i == 7) || (i == 11), (i == 6) ? 1 : 0, 1'b1, d, 1'b0, 1'b0, 1'b0);
        end
        2: add_vec(1'b1, d, i == 1, (i == 3) || (i == 4) || (i == 12), 0, 1'b1, d,
                   1'b0, 1'b0, (i == 3) || (i == 8));
        3: add_vec(1'b1, d, 1'b0, (i % 4) == 0, 0, i == 1, d, 1'b0, i == 1, 1'b0);
        4: add_vec(1'b1, d, (i == 1) || (i == 4), (i % 4) == 0, 0, 1'b1, d, 1'b0, 1'b0, 1'b0);
        5: add_vec(1'b1, d, (i == 1) || (i == 2), (i % 4) == 0, 0, i <= 2, d, 1'b0, i == 2, 1'b0);
        default: add_vec(1'b1, d, i == 1, (i % 4) == 0, 0, 1'b1, d, 1'b0, 1'b0, 1'b0);
      endcase
    end
  endtask

  task automatic apply_vecs();
    for (int i = 0; i < vecs.size(); i++) begin
      beat_t b;
      exp_t  e;
      if (vecs[i].has_beat) begin
        b.data = vecs[i].data; b.user = vecs[i].user; b.last = vecs[i].last; b.hold = vecs[i].hold;
        src_q.push_back(b);
      end
      if (vecs[i].shown) begin
        e.data = vecs[i].exp_data; e.uflow = vecs[i].exp_uflow;
        e.sof = vecs[i].exp_sof; e.eol = vecs[i].exp_eol;
        sb_q.push_back(e);
      end
    end
    vecs.delete();
  endtask

  task automatic drive();
    bus.axis_tkeep = 2'($urandom_range(0, 3));
    if (src_q.size() == 0 || src_q[0].hold > 0) begin
      if (src_q.size() != 0) src_q[0].hold = src_q[0].hold - 1;
      bus.axis_tvalid = 1'b0;
      bus.axis_tuser  = 1'b0;
      bus.axis_tlast  = 1'b0;
      bus.axis_tdata  = 16'h0;
    end else begin
      bus.axis_tvalid = 1'b1;
      bus.axis_tuser  = src_q[0].user;
      bus.axis_tlast  = src_q[0].last;
      bus.axis_tdata  = src_q[0].data;
    end
  endtask

  task automatic monitor();
    int   p, ph, pv;
    exp_t e;
    p  = tb_pos - 1;
    ph = p % HT;
    pv = (p / HT) % VT;
    chk("hsync", vid_hsync, ph == HS_AT);
    chk("vsync", vid_vsync, pv == VS_AT);
    if (vid_de) begin
      chk("de_in_active", ph < HA && pv < VA, 1);
      if (sb_q.size() == 0) begin
        chk("unexpected_de", vid_de, 0);
      end else begin
        e = sb_q.pop_front();
        chk("data", vid_data, e.data);
        chk("err_uflow", err_uflow, e.uflow);
        chk("err_sof", err_sof, e.sof);
        chk("err_eol", err_eol, e.eol);
        if (err_sof) chk("locked_after_sof", locked, 0);
        if (err_uflow || err_eol) chk("locked_on_err", locked, 1);
      end
    end else begin
      chk("data_blank", vid_data, 0);
      chk("err_blank", {err_sof, err_eol, err_uflow}, 0);
    end
    if (prev_locked && !locked) lock_falls++;
    prev_locked = locked;
  endtask

  task automatic step();
    @(negedge vid_clk);
    acc = bus.axis_tvalid && bus.axis_tready;
    @(posedge vid_clk);
    #1;
    tb_pos++;
    monitor();
    if (acc && src_q.size() > 0) src_q.delete(0);
    drive();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tready"}, bus.axis_tready, 0);
    chk({tag, "_de"}, vid_de, 0);
    chk({tag, "_data"}, vid_data, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_errs"}, {err_sof, err_eol, err_uflow}, 0);
    chk({tag, "_hsync"}, vid_hsync, 0);
    chk({tag, "_vsync"}, vid_vsync, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.axis_tvalid = 1'b1;
    bus.axis_tuser  = 1'b0;
    bus.axis_tlast  = 1'b0;
    bus.axis_tdata  = 16'h1234;
    bus.axis_tkeep  = 2'b11;
    #1;
    chk_reset_outputs("rst0");
    @(posedge vid_clk);
    @(posedge vid_clk);
    #1;
    chk_reset_outputs("rst1");
    reset = 1'b0;
    tb_pos = 0;
    drive();

    // Idle: two frames with no stream data, timing must still run.
    for (int c = 0; c < 2 * HT * VT; c++) begin
      step();
      chk("locked_idle", locked, 0);
    end

    // Junk then a sequence of frames exercising each alignment case; the last
    // frame is interrupted by reset after two pixels.
    for (int j = 0; j < 5; j++)
      add_vec(1'b1, 16'hDE00 + 16'(j), 1'b0, j == 4, 0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    add_frame(0);
    add_frame(1);
    add_frame(2);
    add_frame(3);
    add_frame(4);
    add_frame(5);
    add_frame(0);
    add_frame(0);
    apply_vecs();
    drive();
    for (int c = 0; c < 3000 && sb_q.size() > 10; c++) step();
    chk("pre_reset_remaining", sb_q.size(), 10);
    chk("pre_reset_locked", locked, 1);
    chk("lock_falls", lock_falls, 2);

    // Asynchronous reset mid-line.
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(posedge vid_clk);
    #1;
    chk_reset_outputs("held_rst");
    src_q.delete();
    sb_q.delete();
    reset = 1'b0;
    tb_pos = 0;
    prev_locked = 1'b0;

    // Re-lock: SOF beat must be held in HUNT and WAIT until (0,0).
    add_frame(0);
    apply_vecs();
    drive();
    #1;
    chk("hunt_sof_tready", bus.axis_tready, 0);
    step();
    #1;
    chk("wait_tready", bus.axis_tready, 0);
    chk("wait_locked", locked, 0);
    for (int c = 0; c < 500 && sb_q.size() > 0; c++) step();
    chk("relock_drained", sb_q.size(), 0);
    chk("relock_locked", locked, 1);
    for (int c = 0; c < 5; c++) step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
